// File: rtl/hash_msg_feeder.sv
// Byte source for the full_hash core: buffers a host-written message, streams it
// over the Byte/F_dr/F_rtr handshake and collects the digest or flags a timeout.
module hash_msg_feeder #(
    parameter  int MAX_LEN     = 64,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    input  logic [7:0]       ld_byte,
    input  logic             ld_clear,
    input  logic             send,
    output logic             busy,
    output logic [LEN_W-1:0] msg_len,
    output logic             buf_full,
    output logic             start,
    output logic [7:0]       Byte,
    output logic             F_dr,
    output logic             End_Of_File,
    input  logic             F_rtr,
    input  logic [31:0]      R_h,
    input  logic             H_ready,
    output logic [31:0]      digest,
    output logic             done,
    output logic             timeout
);

    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit TO_EN  = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, START, SEND, EOF_WAIT} state_t;

    state_t           state_q;
    logic [7:0]       mem [1 << ADDR_W];
    logic [LEN_W-1:0] msg_len_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] rd_ptr_q;
    logic [LEN_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, start_q, fdr_q, eof_q, done_q, timeout_q;
    logic [7:0]       byte_q;
    logic [31:0]      digest_q;
    logic             full_w;
    logic             wr_en;
    logic             last_xfer;

    assign full_w    = (msg_len_q == LEN_W'(MAX_LEN));
    assign wr_en     = (state_q == IDLE) && !send && !ld_clear && ld_valid && !full_w;
    assign rd_ptr_d  = rd_ptr_q + LEN_W'(1);
    assign last_xfer = (rd_ptr_d == len_q);

    // Buffer contents survive reset and completion so a message can be re-sent.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[msg_len_q[ADDR_W-1:0]] <= ld_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            msg_len_q <= '0;
            len_q     <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            fdr_q     <= 1'b0;
            eof_q     <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            byte_q    <= '0;
            digest_q  <= '0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (send) begin
                        len_q   <= msg_len_q;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                        state_q <= START;
                    end else if (ld_clear) begin
                        msg_len_q <= '0;
                    end else if (wr_en) begin
                        msg_len_q <= msg_len_q + LEN_W'(1);
                    end
                end
                START: begin
                    start_q  <= 1'b0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                    if (len_q != '0) begin
                        fdr_q   <= 1'b1;
                        byte_q  <= mem[0];
                        state_q <= SEND;
                    end else begin
                        eof_q   <= 1'b1;
                        state_q <= EOF_WAIT;
                    end
                end
                SEND: begin
                    if (F_rtr) begin
                        if (last_xfer) begin
                            fdr_q   <= 1'b0;
                            eof_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= EOF_WAIT;
                        end else begin
                            rd_ptr_q <= rd_ptr_d;
                            byte_q   <= mem[rd_ptr_d[ADDR_W-1:0]];
                        end
                    end
                end
                EOF_WAIT: begin
                    // H_ready takes priority over a timeout expiring on the same edge.
                    if (H_ready) begin
                        digest_q <= R_h;
                        done_q   <= 1'b1;
                        eof_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                        timeout_q <= 1'b1;
                        eof_q     <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign msg_len     = msg_len_q;
    assign buf_full    = full_w;
    assign start       = start_q;
    assign Byte        = byte_q;
    assign F_dr        = fdr_q;
    assign End_Of_File = eof_q;
    assign digest      = digest_q;
    assign done        = done_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Scoreboard bench for hash_msg_feeder: a model buffer feeds expected bytes at send,
// a negedge monitor pops them on each handshake transfer.
module tb_hash_msg_feeder;

    localparam int MAX_LEN = 64;
    localparam int TO_CYC  = 16;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             ld_valid, ld_clear, send;
    logic [7:0]       ld_byte;
    logic             busy, buf_full, start, F_dr, End_Of_File, done, timeout;
    logic [LEN_W-1:0] msg_len;
    logic [7:0]       Byte;
    logic             F_rtr, H_ready;
    logic [31:0]      R_h, digest;

    hash_msg_feeder #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_byte(ld_byte),
        .ld_clear(ld_clear), .send(send), .busy(busy), .msg_len(msg_len),
        .buf_full(buf_full), .start(start), .Byte(Byte), .F_dr(F_dr),
        .End_Of_File(End_Of_File), .F_rtr(F_rtr), .R_h(R_h), .H_ready(H_ready),
        .digest(digest), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0]  exp_q[$];
    logic [7:0]  mbuf[MAX_LEN];
    int          mlen = 0;
    logic [31:0] exp_digest = '0;

    int   xfers = 0, starts = 0, dones = 0, touts = 0;
    logic stall_pend = 1'b0;
    logic [7:0] sbyte = '0;

    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_fdr", 32'(F_dr), 32'd1);
                check("stall_byte", 32'(Byte), 32'(sbyte));
            end
            stall_pend = F_dr && !F_rtr;
            sbyte      = Byte;
            if (F_dr && F_rtr) begin
                xfers++;
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("byte", 32'(Byte), 32'(exp_q.pop_front()));
            end
            if (End_Of_File) check("eof_fdr", 32'(F_dr), 32'd0);
            if (start)   starts++;
            if (done)    dones++;
            if (timeout) touts++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_byte  = b;
        tick();
        ld_valid = 1'b0;
        if (mlen < MAX_LEN) begin
            mbuf[mlen] = b;
            mlen++;
        end
    endtask

    task automatic clear();
        ld_clear = 1'b1;
        tick();
        ld_clear = 1'b0;
        mlen = 0;
        check("clear_len", 32'(msg_len), 32'd0);
    endtask

    task automatic do_send();
        for (int i = 0; i < mlen; i++) exp_q.push_back(mbuf[i]);
        send = 1'b1;
        tick();
        send = 1'b0;
        check("start_n1", 32'(start), 32'd1);
        check("busy_n1", 32'(busy), 32'd1);
    endtask

    task automatic wait_eof(input int c0, output int cyc);
        cyc = c0;
        while (!End_Of_File && cyc < 400) begin
            tick();
            cyc++;
        end
        check("eof_seen", 32'(End_Of_File), 32'd1);
    endtask

    // Hasher model: H_ready held during the third cycle after End_Of_File rose.
    task automatic answer(input logic [31:0] rh);
        repeat (3) tick();
        check("eof_hold", 32'(End_Of_File), 32'd1);
        check("done_early", 32'(done), 32'd0);
        H_ready = 1'b1;
        R_h     = rh;
        tick();
        H_ready = 1'b0;
        R_h     = $urandom;
        exp_digest = rh;
        check("done", 32'(done), 32'd1);
        check("digest", digest, exp_digest);
        check("eof_fall", 32'(End_Of_File), 32'd0);
        check("busy_fall", 32'(busy), 32'd0);
        check("no_timeout", 32'(timeout), 32'd0);
        tick();
        check("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, x0, s0, d0, t0, stall;
        logic [7:0] msg [9];
        msg = '{8'h43, 8'h69, 8'h61, 8'h6F, 8'h4D, 8'h6F, 8'h6E, 8'h64, 8'h6F};
        rst = 1'b1; ld_valid = 1'b0; ld_clear = 1'b0; send = 1'b0; ld_byte = '0;
        F_rtr = 1'b1; H_ready = 1'b0; R_h = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_len", 32'(msg_len), 32'd0);
        check("rst_byte", 32'(Byte), 32'd0);
        check("rst_digest", digest, 32'd0);
        rst = 1'b0;
        tick();

        // 1: CiaoMondo, F_rtr constantly high
        for (int i = 0; i < 9; i++) load(msg[i]);
        check("t1_len", 32'(msg_len), 32'd9);
        x0 = xfers; s0 = starts; d0 = dones;
        do_send();
        wait_eof(1, cyc);
        check("t1_eof_lat", 32'(cyc), 32'd11);
        answer(32'hDEADBEEF);
        check("t1_starts", 32'(starts - s0), 32'd1);
        check("t1_dones", 32'(dones - d0), 32'd1);
        check("t1_xfers", 32'(xfers - x0), 32'd9);
        check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // 2: resend retained buffer with stall then toggling F_rtr
        x0 = xfers; stall = 0;
        do_send();
        cyc = 1;
        while (!End_Of_File && cyc < 400) begin
            if (xfers - x0 < 3) F_rtr = 1'b1;
            else if (stall < 5) begin F_rtr = 1'b0; stall++; end
            else F_rtr = ~F_rtr;
            tick();
            cyc++;
        end
        F_rtr = 1'b1;
        check("t2_eof", 32'(End_Of_File), 32'd1);
        check("t2_xfers", 32'(xfers - x0), 32'd9);
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);
        answer(32'hA5A50002);

        // 3: empty message; stray H_ready in IDLE first
        clear();
        H_ready = 1'b1; R_h = 32'h11111111;
        tick();
        H_ready = 1'b0;
        check("t3_stray_done", 32'(done), 32'd0);
        check("t3_stray_digest", digest, exp_digest);
        x0 = xfers;
        do_send();
        wait_eof(1, cyc);
        check("t3_eof_lat", 32'(cyc), 32'd2);
        answer(32'h12345678);
        check("t3_xfers", 32'(xfers - x0), 32'd0);

        // 4: overfill, then loads/clear/send while busy
        clear();
        for (int i = 0; i < MAX_LEN + 1; i++) load(8'(i * 13 + 7));
        check("t4_len", 32'(msg_len), 32'(MAX_LEN));
        check("t4_full", 32'(buf_full), 32'd1);
        x0 = xfers; s0 = starts;
        do_send();
        ld_valid = 1'b1; ld_byte = 8'hAA;
        tick();
        ld_clear = 1'b1; send = 1'b1;
        tick();
        ld_clear = 1'b0; send = 1'b0;
        tick();
        ld_valid = 1'b0;
        check("t4_len_busy", 32'(msg_len), 32'(MAX_LEN));
        wait_eof(4, cyc);
        check("t4_eof_lat", 32'(cyc), 32'(MAX_LEN + 2));
        answer(32'hCAFEF00D);
        check("t4_xfers", 32'(xfers - x0), 32'(MAX_LEN));
        check("t4_starts", 32'(starts - s0), 32'd1);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);
        check("t4_len_after", 32'(msg_len), 32'(MAX_LEN));

        // 5: hasher never answers
        clear();
        load(8'h31); load(8'h32);
        do_send();
        wait_eof(1, cyc);
        check("t5_eof_lat", 32'(cyc), 32'd4);
        d0 = dones; t0 = touts; cyc = 0;
        while (!timeout && cyc < 100) begin
            tick();
            cyc++;
        end
        check("t5_to_lat", 32'(cyc), 32'(TO_CYC));
        check("t5_eof", 32'(End_Of_File), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_digest", digest, exp_digest);
        tick();
        check("t5_to_pulse", 32'(timeout), 32'd0);
        check("t5_dones", 32'(dones - d0), 32'd0);
        check("t5_touts", 32'(touts - t0), 32'd1);

        // 6: reset mid-SEND after 4 transfers
        clear();
        for (int i = 0; i < 8; i++) load(8'(8'h80 + i));
        x0 = xfers;
        do_send();
        cyc = 0;
        while (xfers - x0 < 4 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("t6_xfers_pre", 32'(xfers - x0), 32'd4);
        rst = 1'b1;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_fdr", 32'(F_dr), 32'd0);
        check("t6_byte", 32'(Byte), 32'd0);
        check("t6_start", 32'(start), 32'd0);
        check("t6_eof", 32'(End_Of_File), 32'd0);
        check("t6_digest", digest, 32'd0);
        check("t6_len", 32'(msg_len), 32'd0);
        check("t6_full", 32'(buf_full), 32'd0);
        exp_q.delete();
        mlen = 0;
        exp_digest = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) load(8'(8'h50 + i));
        x0 = xfers;
        do_send();
        wait_eof(1, cyc);
        check("t6_eof_lat", 32'(cyc), 32'd7);
        answer(32'h0BADF00D);
        check("t6_xfers", 32'(xfers - x0), 32'd5);
        check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hash_msg_feeder.md
Name: hash_msg_feeder

Overview:
- Transmit-side byte source for the full_hash core.
- Buffers a message written by a host, then issues the start pulse.
- Streams the bytes over the Byte/F_dr/F_rtr handshake and raises End_Of_File.
- Captures R_h when H_ready arrives and reports done, or timeout if the hasher never answers.

Parameters:
MAX_LEN, 64, message buffer depth in bytes (power of two not required).
TIMEOUT_CYC, 1024, max cycles to wait for H_ready after End_Of_File rises; 0 disables the timeout.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
ld_valid  in  1  write ld_byte into buffer at next free address
ld_byte  in  8  byte to store
ld_clear  in  1  empty the buffer (msg_len -> 0)
send  in  1  begin transmitting buffered message
busy  out  1  high from send acceptance until done/timeout
msg_len  out  LEN_W  bytes currently buffered, LEN_W = $clog2(MAX_LEN+1)
buf_full  out  1  msg_len == MAX_LEN
start  out  1  one-cycle start pulse to hasher
Byte  out  8  data byte to hasher
F_dr  out  1  data ready: Byte valid
End_Of_File  out  1  message complete, held until H_ready or timeout
F_rtr  in  1  hasher ready to receive
R_h  in  32  hash result from hasher
H_ready  in  1  hash result valid
digest  out  32  last captured R_h
done  out  1  one-cycle pulse, digest updated
timeout  out  1  one-cycle pulse, hasher did not answer

Behaviour:
- Reset (async, immediate):
  - All outputs 0, msg_len 0, state IDLE, timeout counter 0.
  - Buffer contents don't-care.
- States: IDLE -> START -> SEND -> EOF_WAIT -> IDLE.
- IDLE, buffer loading:
  - ld_valid with !buf_full writes buf[msg_len] and increments msg_len.
  - ld_valid when full is dropped.
  - ld_clear sets msg_len 0 and beats ld_valid in the same cycle; that byte is dropped.
- IDLE, send:
  - send moves to START; busy=1 from the next cycle.
  - send beats ld_valid and ld_clear in the same cycle; both are ignored.
  - Length is latched at send.
- While busy: ld_valid, ld_clear and send are all ignored.
- START: start=1 for exactly one cycle. Go to SEND if length > 0, else EOF_WAIT.
- SEND, handshake (valid/ready):
  - F_dr=1 and Byte=buf[rd_ptr], held stable until a rising edge where F_rtr=1; that edge is one transfer.
  - Back-to-back transfers are allowed while F_rtr stays high.
  - F_rtr low stalls indefinitely; there is no timeout in SEND.
- SEND, last byte: after the last byte is accepted, F_dr=0 and state EOF_WAIT in the next cycle.
- EOF_WAIT:
  - End_Of_File=1, F_dr=0; the counter increments each cycle.
  - At the edge where H_ready=1: digest<=R_h, done=1 for one cycle, End_Of_File=0, busy=0, IDLE.
  - If the counter reaches TIMEOUT_CYC (nonzero) first: timeout=1 for one cycle, End_Of_File=0, busy=0, IDLE, digest unchanged.
  - H_ready and the timeout on the same edge: H_ready wins.
- H_ready outside EOF_WAIT is ignored.
- The buffer is retained after completion, so the same message can be re-sent with send.
- Latency, send sampled at edge N:
  - start is high in cycle N+1.
  - F_dr is high from cycle N+2.
  - With F_rtr constantly 1, L bytes occupy cycles N+2..N+1+L, and End_Of_File rises at N+2+L.
- Byte output keeps its last value when F_dr=0 (0 after reset).

Test Plan:
1. Load "CiaoMondo" (9 bytes), send, F_rtr=1 constantly, hasher model returns R_h=0xDEADBEEF with H_ready 3 cycles after End_Of_File -> single start pulse; Byte sequence 0x43,0x69,0x61,0x6F,0x4D,0x6F,0x6E,0x64,0x6F; End_Of_File rises at N+11; digest=0xDEADBEEF; done pulses once; busy falls.
2. Same message, F_rtr low for 5 cycles after byte 3 and then toggling every cycle -> Byte/F_dr stable while stalled; exactly 9 transfers, none duplicated or skipped.
3. ld_clear then send with msg_len=0 -> start pulse; F_dr never asserted; End_Of_File high the cycle after start; done on H_ready.
4. MAX_LEN=64, write 65 bytes -> msg_len=64, buf_full=1, 65th byte absent from the transmitted stream; ld_valid during busy leaves msg_len unchanged.
5. TIMEOUT_CYC=16, H_ready never asserted -> timeout pulses exactly 16 cycles after End_Of_File rises; done=0; digest keeps its previous value; busy=0.
6. Assert rst mid-SEND after 4 transfers -> all outputs 0 immediately (before next edge), msg_len=0; after release, a fresh load and send completes normally.
